// File: rtl/vid_timing_scanout.sv
// ---------------------------------------------------------------------------
// vid_timing_scanout
// Video scanout engine. This is a programmable H/V timing generator that also
// produces VRAM fetch addresses, replicates pixels, and aligns all display
// outputs.
//
// Ports:
//   i_Clk, i_nRst          pixel clock (rising edge), asynchronous active-low reset
//   i_AV_SlaveSel          Avalon slave select
//   i_AV_RegAddr           register word index (0..7)
//   i_AV_Read/i_AV_Write   Avalon read / write strobes
//   i_AV_WriteData         write data
//   o_AV_ReadData          registered read data, 0 when no read is in progress
//   o_AV_WaitRequest       always 0
//   o_FetchEn/o_FetchAddr  VRAM read request (registered)
//   i_FetchData            VRAM data, valid FETCH_LAT cycles after o_FetchEn
//   o_HSync/o_VSync        sync outputs; polarity comes from CTRL (1 = active-high)
//   o_nBlank               high in the active area
//   o_Pixel                pixel output, 0 when blanked
//   o_VBlankIrq            one-cycle pulse when the first vertical-blank line starts
// ---------------------------------------------------------------------------
module vid_timing_scanout #(
    parameter int PIX_W     = 16,
    parameter int ADDR_W    = 15,
    parameter int SCALE     = 0,
    parameter int FETCH_LAT = 1,
    parameter int CNT_W     = 12
) (
    input  logic              i_Clk,
    input  logic              i_nRst,
    input  logic              i_AV_SlaveSel,
    input  logic [2:0]        i_AV_RegAddr,
    input  logic              i_AV_Read,
    input  logic              i_AV_Write,
    input  logic [31:0]       i_AV_WriteData,
    output logic [31:0]       o_AV_ReadData,
    output logic              o_AV_WaitRequest,
    output logic              o_FetchEn,
    output logic [ADDR_W-1:0] o_FetchAddr,
    input  logic [PIX_W-1:0]  i_FetchData,
    output logic              o_HSync,
    output logic              o_VSync,
    output logic              o_nBlank,
    output logic [PIX_W-1:0]  o_Pixel,
    output logic              o_VBlankIrq
);

    typedef struct packed {
        logic [CNT_W-1:0]  hAct, hTot, hSS, hSE;
        logic [CNT_W-1:0]  vAct, vTot, vSS, vSE;
        logic [ADDR_W-1:0] base;
    } timing_t;

    typedef struct packed {
        logic hs, vs, act, irq;
    } disp_t;

    localparam timing_t TIMING_RST = '{
        hAct: CNT_W'(640), hTot: CNT_W'(800), hSS: CNT_W'(656), hSE: CNT_W'(752),
        vAct: CNT_W'(480), vTot: CNT_W'(525), vSS: CNT_W'(490), vSE: CNT_W'(492),
        base: '0};
    localparam logic [CNT_W-1:0] SUB_MASK = CNT_W'((1 << SCALE) - 1);
    localparam int DLY = FETCH_LAT + 2;

    logic [2:0]        r_Ctrl;
    timing_t           r_Sh, r_Act;
    logic [CNT_W-1:0]  r_H, r_V;
    logic [15:0]       r_Frame;
    logic [ADDR_W-1:0] r_LinePtr;
    logic              r_FetchEn;
    logic [ADDR_W-1:0] r_FetchAddr;
    logic              r_DataVld [FETCH_LAT];
    logic [PIX_W-1:0]  r_PixHold;
    disp_t             r_Dly [DLY];
    logic [31:0]       r_RdData;

    logic             w_Wr, w_Rd, w_En, w_HEnd, w_VEnd, w_Load, w_LineStep;
    logic [CNT_W-1:0] w_HLast, w_VLast, w_VNext;
    logic             w_Active, w_HSyncAct, w_VSyncAct, w_Irq, w_FetchNow, w_InVBlank;
    logic             w_unused;

    assign w_Wr = i_AV_SlaveSel && i_AV_Write;
    assign w_Rd = i_AV_SlaveSel && i_AV_Read;
    assign w_En = r_Ctrl[0];
    assign w_unused = &{1'b0, i_AV_WriteData};

    // A TOTAL of 0 is treated as 1. Using >= means a counter that is somehow
    // past the programmed end still wraps instead of running away.
    assign w_HLast = (r_Act.hTot == '0) ? '0 : r_Act.hTot - CNT_W'(1);
    assign w_VLast = (r_Act.vTot == '0) ? '0 : r_Act.vTot - CNT_W'(1);
    assign w_HEnd  = r_H >= w_HLast;
    assign w_VEnd  = r_V >= w_VLast;
    // Shadow timing becomes live at the frame wrap, or continuously while disabled.
    assign w_Load  = !w_En || (w_HEnd && w_VEnd);
    // The line pointer advances only after the last replicated copy of a source line.
    assign w_VNext    = r_V + CNT_W'(1);
    assign w_LineStep = (w_VNext & SUB_MASK) == '0;

    // These are the decodes at counter time; they feed the alignment delay line.
    assign w_Active   = w_En && (r_H < r_Act.hAct) && (r_V < r_Act.vAct);
    assign w_HSyncAct = w_En && (r_H >= r_Act.hSS) && (r_H < r_Act.hSE);
    assign w_VSyncAct = w_En && (r_V >= r_Act.vSS) && (r_V < r_Act.vSE);
    assign w_Irq      = w_En && (r_H == '0) && (r_V == r_Act.vAct);
    assign w_FetchNow = w_Active && ((r_H & SUB_MASK) == '0);
    assign w_InVBlank = r_V >= r_Act.vAct;

    // Register writes go to CTRL or to the shadow timing set.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_Ctrl <= '0;
            r_Sh   <= TIMING_RST;
        end else if (w_Wr) begin
            case (i_AV_RegAddr)
                3'd0: r_Ctrl <= i_AV_WriteData[2:0];
                3'd1: begin
                    r_Sh.hAct <= i_AV_WriteData[CNT_W-1:0];
                    r_Sh.hTot <= i_AV_WriteData[16 +: CNT_W];
                end
                3'd2: begin
                    r_Sh.hSS <= i_AV_WriteData[CNT_W-1:0];
                    r_Sh.hSE <= i_AV_WriteData[16 +: CNT_W];
                end
                3'd3: begin
                    r_Sh.vAct <= i_AV_WriteData[CNT_W-1:0];
                    r_Sh.vTot <= i_AV_WriteData[16 +: CNT_W];
                end
                3'd4: begin
                    r_Sh.vSS <= i_AV_WriteData[CNT_W-1:0];
                    r_Sh.vSE <= i_AV_WriteData[16 +: CNT_W];
                end
                3'd5: r_Sh.base <= i_AV_WriteData[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // This block holds the raster counters, the active timing copy, and the line
    // pointer. The line pointer is built by accumulation, so no multiplier is needed.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_Act     <= TIMING_RST;
            r_H       <= '0;
            r_V       <= '0;
            r_Frame   <= '0;
            r_LinePtr <= '0;
        end else begin
            if (w_Load) begin
                r_Act     <= r_Sh;
                r_LinePtr <= r_Sh.base;
            end else if (w_HEnd && w_LineStep) begin
                r_LinePtr <= r_LinePtr + ADDR_W'(r_Act.hAct >> SCALE);
            end
            if (!w_En) begin
                r_H <= '0;
                r_V <= '0;
            end else if (w_HEnd) begin
                r_H <= '0;
                if (w_VEnd) begin
                    r_V     <= '0;
                    r_Frame <= r_Frame + 16'd1;
                end else begin
                    r_V <= w_VNext;
                end
            end else begin
                r_H <= r_H + CNT_W'(1);
            end
        end
    end

    // This block drives the fetch request and tracks when its data returns. The
    // pixel register only loads on returned data, so it holds the value across
    // the replicated cycles.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_FetchEn   <= 1'b0;
            r_FetchAddr <= '0;
            r_PixHold   <= '0;
            for (int i = 0; i < FETCH_LAT; i++) r_DataVld[i] <= 1'b0;
        end else begin
            r_FetchEn    <= w_FetchNow;
            r_FetchAddr  <= r_LinePtr + ADDR_W'(r_H >> SCALE);
            r_DataVld[0] <= r_FetchEn;
            for (int i = 1; i < FETCH_LAT; i++) r_DataVld[i] <= r_DataVld[i-1];
            if (r_DataVld[FETCH_LAT-1]) r_PixHold <= i_FetchData;
        end
    end

    // This delay line matches the timing decodes to the fetch and return path.
    // Reset flushes it to blank with syncs inactive.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            for (int i = 0; i < DLY; i++) r_Dly[i] <= '0;
        end else begin
            r_Dly[0] <= '{hs: w_HSyncAct, vs: w_VSyncAct, act: w_Active, irq: w_Irq};
            for (int i = 1; i < DLY; i++) r_Dly[i] <= r_Dly[i-1];
        end
    end

    // Register readback. Reads return the shadow (programmed) values, and the
    // output is 0 whenever no read is in progress.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            r_RdData <= '0;
        end else if (w_Rd) begin
            case (i_AV_RegAddr)
                3'd0:    r_RdData <= 32'(r_Ctrl);
                3'd1:    r_RdData <= (32'(r_Sh.hTot) << 16) | 32'(r_Sh.hAct);
                3'd2:    r_RdData <= (32'(r_Sh.hSE) << 16) | 32'(r_Sh.hSS);
                3'd3:    r_RdData <= (32'(r_Sh.vTot) << 16) | 32'(r_Sh.vAct);
                3'd4:    r_RdData <= (32'(r_Sh.vSE) << 16) | 32'(r_Sh.vSS);
                3'd5:    r_RdData <= 32'(r_Sh.base);
                3'd6:    r_RdData <= {r_Frame, 15'd0, w_InVBlank};
                default: r_RdData <= '0;
            endcase
        end else begin
            r_RdData <= '0;
        end
    end

    assign o_AV_ReadData    = r_RdData;
    assign o_AV_WaitRequest = 1'b0;
    assign o_FetchEn        = r_FetchEn;
    assign o_FetchAddr      = r_FetchAddr;
    assign o_HSync          = r_Dly[DLY-1].hs ? r_Ctrl[1] : ~r_Ctrl[1];
    assign o_VSync          = r_Dly[DLY-1].vs ? r_Ctrl[2] : ~r_Ctrl[2];
    assign o_nBlank         = r_Dly[DLY-1].act;
    assign o_Pixel          = r_Dly[DLY-1].act ? r_PixHold : '0;
    assign o_VBlankIrq      = r_Dly[DLY-1].irq;

endmodule

// File: tb/tb_vid_timing_scanout.sv
// ---------------------------------------------------------------------------
// tb_vid_timing_scanout
// Directed bench for vid_timing_scanout with SCALE=1 and FETCH_LAT=3.
// Expected per-cycle display and fetch outputs are generated from the
// programmed timing (division and multiplication on the raster index). They
// are queued before each stimulus and popped one per clock.
// ---------------------------------------------------------------------------
module tb_vid_timing_scanout;
    localparam int PIX_W     = 16;
    localparam int ADDR_W    = 15;
    localparam int SCALE     = 1;
    localparam int FETCH_LAT = 3;
    localparam int CNT_W     = 12;
    localparam int OUT_LAT   = FETCH_LAT + 2;

    typedef struct {
        int ha, ht, hss, hse, va, vt, vss, vse, base;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic hs, vs, nb, irq;
        logic [PIX_W-1:0] pix;
    } out_t;

    typedef struct packed {
        logic fe;
        logic [ADDR_W-1:0] addr;
    } fe_t;

    logic              clk = 1'b0;
    logic              nRst = 1'b1;
    logic              sel = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0]        regAddr = '0;
    logic [31:0]       wData = '0;
    logic [31:0]       rData;
    logic              waitReq, fetchEn, hSync, vSync, nBlank, vbIrq;
    logic [ADDR_W-1:0] fetchAddr;
    logic [PIX_W-1:0]  fetchData, pixel;
    logic [ADDR_W-1:0] vramPipe [FETCH_LAT];

    out_t outQ[$];
    fe_t  feQ[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    vid_timing_scanout #(
        .PIX_W(PIX_W), .ADDR_W(ADDR_W), .SCALE(SCALE),
        .FETCH_LAT(FETCH_LAT), .CNT_W(CNT_W)
    ) dut (
        .i_Clk(clk), .i_nRst(nRst),
        .i_AV_SlaveSel(sel), .i_AV_RegAddr(regAddr), .i_AV_Read(rd),
        .i_AV_Write(wr), .i_AV_WriteData(wData), .o_AV_ReadData(rData),
        .o_AV_WaitRequest(waitReq),
        .o_FetchEn(fetchEn), .o_FetchAddr(fetchAddr), .i_FetchData(fetchData),
        .o_HSync(hSync), .o_VSync(vSync), .o_nBlank(nBlank),
        .o_Pixel(pixel), .o_VBlankIrq(vbIrq)
    );

    always #5 clk = ~clk;

    // VRAM model: the returned data is the requested address, delivered FETCH_LAT cycles later.
    always @(posedge clk) begin
        vramPipe[0] <= fetchAddr;
        for (int i = 1; i < FETCH_LAT; i++) vramPipe[i] <= vramPipe[i-1];
    end
    assign fetchData = PIX_W'(vramPipe[FETCH_LAT-1]);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge, and pop any queued expectations.
    task automatic step();
        out_t expO, gotO;
        fe_t  expF;
        @(posedge clk);
        #1;
        if (outQ.size() > 0) begin
            expO = outQ.pop_front();
            gotO = {hSync, vSync, nBlank, vbIrq, pixel};
            checks++;
            assert (gotO === expO) else begin
                failures++;
                $error("[TB] FAIL disp cyc=%0d observed=%h expected=%h", cyc, gotO, expO);
            end
        end
        if (feQ.size() > 0) begin
            expF = feQ.pop_front();
            checks++;
            assert (fetchEn === expF.fe) else begin
                failures++;
                $error("[TB] FAIL fetchEn cyc=%0d observed=%b expected=%b", cyc, fetchEn, expF.fe);
            end
            if (expF.fe) begin
                checks++;
                assert (fetchAddr === expF.addr) else begin
                    failures++;
                    $error("[TB] FAIL fetchAddr cyc=%0d observed=%h expected=%h", cyc, fetchAddr, expF.addr);
                end
            end
        end
        cyc++;
    endtask

    task automatic applyStimulus(input logic [2:0] idx, input logic [31:0] data);
        sel = 1'b1; wr = 1'b1; regAddr = idx; wData = data;
        step();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic readReg(input logic [2:0] idx, input logic [31:0] exp, input string tag);
        sel = 1'b1; rd = 1'b1; regAddr = idx;
        step();
        sel = 1'b0; rd = 1'b0;
        checkOutput(tag, rData, exp);
    endtask

    // Outputs still come from the disabled pipeline during the first cycles after enable.
    task automatic pushPrefix(input cfg_t c);
        out_t o;
        fe_t  f;
        o = {!c.hpol, !c.vpol, 1'b0, 1'b0, {PIX_W{1'b0}}};
        f = '0;
        repeat (OUT_LAT) outQ.push_back(o);
        feQ.push_back(f);
    endtask

    task automatic pushCycles(input cfg_t c, input int n);
        int h, v, addr;
        bit act;
        out_t o;
        fe_t f;
        for (int k = 0; k < n; k++) begin
            h = k % c.ht;
            v = (k / c.ht) % c.vt;
            act = (h < c.ha) && (v < c.va);
            addr = (c.base + (v >> SCALE) * (c.ha >> SCALE) + (h >> SCALE)) % (1 << ADDR_W);
            o.hs  = (h >= c.hss && h < c.hse) ? c.hpol : !c.hpol;
            o.vs  = (v >= c.vss && v < c.vse) ? c.vpol : !c.vpol;
            o.nb  = act;
            o.irq = (h == 0) && (v == c.va);
            o.pix = act ? PIX_W'(addr) : '0;
            outQ.push_back(o);
            f.fe   = act && ((h % (1 << SCALE)) == 0);
            f.addr = ADDR_W'(addr);
            feQ.push_back(f);
        end
    endtask

    task automatic runUntilEmpty();
        while (outQ.size() > 0 || feQ.size() > 0) step();
    endtask

    initial begin
        cfg_t dflt, cfgA, cfgB, cfgP, dfl0;
        dflt = '{ha:640, ht:800, hss:656, hse:752, va:480, vt:525, vss:490, vse:492,
                 base:'h100, hpol:0, vpol:0};
        cfgA = '{ha:16, ht:24, hss:18, hse:20, va:6, vt:8, vss:6, vse:7,
                 base:'h100, hpol:0, vpol:0};
        cfgB = cfgA;  cfgB.ha = 8;  cfgB.ht = 12;
        cfgP = cfgB;  cfgP.hpol = 1; cfgP.vpol = 1;
        dfl0 = dflt;  dfl0.base = 0;

        // Reset state
        #2 nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hsync", 32'(hSync), 32'd1);
        checkOutput("rst_vsync", 32'(vSync), 32'd1);
        checkOutput("rst_nblank", 32'(nBlank), 32'd0);
        checkOutput("rst_pixel", 32'(pixel), 32'd0);
        checkOutput("rst_fetchen", 32'(fetchEn), 32'd0);
        checkOutput("rst_irq", 32'(vbIrq), 32'd0);
        checkOutput("rst_waitreq", 32'(waitReq), 32'd0);
        checkOutput("rst_rdata", rData, 32'd0);
        nRst = 1'b1;
        step();

        // Register defaults and readback
        readReg(3'd0, 32'h0000_0000, "ctrl_rst");
        readReg(3'd1, 32'h0320_0280, "ha_rst");
        readReg(3'd2, 32'h02F0_0290, "hs_rst");
        readReg(3'd3, 32'h020D_01E0, "va_rst");
        readReg(3'd4, 32'h01EC_01EA, "vs_rst");
        readReg(3'd5, 32'h0000_0000, "base_rst");
        readReg(3'd6, 32'h0000_0000, "status_rst");
        step();
        checkOutput("rdata_idle", rData, 32'd0);
        applyStimulus(3'd7, 32'hFFFF_FFFF);
        readReg(3'd7, 32'h0000_0000, "reserved");
        applyStimulus(3'd5, 32'h0000_0100);
        readReg(3'd5, 32'h0000_0100, "base_rb");

        // Default timing: first three lines. This covers sync placement, line
        // replication, and the line-2 base.
        $display("[TB] default timing, BASE=0x100");
        pushPrefix(dflt);
        pushCycles(dflt, 1620);
        applyStimulus(3'd0, 32'h1);
        runUntilEmpty();
        applyStimulus(3'd0, 32'h0);
        repeat (OUT_LAT + 2) step();

        // Small timing, with a mid-frame HA change that must wait for the wrap
        $display("[TB] small timing with mid-frame HA rewrite");
        applyStimulus(3'd1, 32'h0018_0010);
        applyStimulus(3'd2, 32'h0014_0012);
        applyStimulus(3'd3, 32'h0008_0006);
        applyStimulus(3'd4, 32'h0007_0006);
        readReg(3'd2, 32'h0014_0012, "hs_rb");
        pushPrefix(cfgA);
        pushCycles(cfgA, 192);
        pushCycles(cfgB, 96);
        applyStimulus(3'd0, 32'h1);
        repeat (49) step();
        applyStimulus(3'd1, 32'h000C_0008);
        repeat (99) step();
        readReg(3'd6, 32'h0000_0001, "status_vblank");
        runUntilEmpty();
        readReg(3'd6, 32'h0002_0000, "status_f2");
        step();
        checkOutput("rdata_after_rd", rData, 32'd0);
        applyStimulus(3'd0, 32'h0);
        repeat (OUT_LAT + 2) step();

        // Inverted sync polarity, with one IRQ per frame
        $display("[TB] active-high syncs");
        pushPrefix(cfgP);
        pushCycles(cfgP, 192);
        applyStimulus(3'd0, 32'h7);
        runUntilEmpty();
        readReg(3'd6, 32'h0004_0000, "status_f4");

        // Asynchronous reset in the middle of an active line
        $display("[TB] async reset mid-line");
        checkOutput("pre_rst_nblank", 32'(nBlank), 32'd1);
        checkOutput("pre_rst_pixel", 32'(pixel), 32'h0100);
        nRst = 1'b0;
        #1;
        checkOutput("mid_rst_hsync", 32'(hSync), 32'd1);
        checkOutput("mid_rst_vsync", 32'(vSync), 32'd1);
        checkOutput("mid_rst_nblank", 32'(nBlank), 32'd0);
        checkOutput("mid_rst_pixel", 32'(pixel), 32'd0);
        checkOutput("mid_rst_fetchen", 32'(fetchEn), 32'd0);
        checkOutput("mid_rst_fetchaddr", 32'(fetchAddr), 32'd0);
        checkOutput("mid_rst_rdata", rData, 32'd0);
        @(posedge clk);
        #1 nRst = 1'b1;
        readReg(3'd1, 32'h0320_0280, "ha_after_rst");
        pushPrefix(dfl0);
        pushCycles(dfl0, 40);
        applyStimulus(3'd0, 32'h1);
        runUntilEmpty();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
